// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-bit validation at mid-bit,
// mid-bit data sampling, stop-bit check with framing-error pulse and line-low recovery.
module uart_rx #(
   parameter int CLKS_PER_BIT = 435
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] d_out,
   output logic       valid,
   output logic       busy,
   output logic       frame_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   logic          r_rx_m;
   logic          r_rx_s;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shreg;
   logic [7:0]    r_d_out;
   logic          r_valid;
   logic          r_busy;
   logic          r_frame_err;

   state_t        w_state;
   logic [CW-1:0] w_cnt;
   logic [2:0]    w_bit_idx;
   logic [7:0]    w_shreg;
   logic [7:0]    w_d_out;
   logic          w_valid;
   logic          w_busy;
   logic          w_frame_err;

   // Two-flop synchronizer; idle-high reset value avoids a false start after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
      end else begin
         r_rx_m <= rx;
         r_rx_s <= r_rx_m;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= 3'd0;
         r_shreg     <= 8'h00;
         r_d_out     <= 8'h00;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_bit_idx   <= w_bit_idx;
         r_shreg     <= w_shreg;
         r_d_out     <= w_d_out;
         r_valid     <= w_valid;
         r_busy      <= w_busy;
         r_frame_err <= w_frame_err;
      end
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_bit_idx   = r_bit_idx;
      w_shreg     = r_shreg;
      w_d_out     = r_d_out;
      w_valid     = 1'b0;
      w_busy      = r_busy;
      w_frame_err = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_cnt   = '0;
               w_busy  = 1'b1;
               w_state = S_START;
            end else begin
               w_busy  = 1'b0;
            end
         end
         S_START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt = '0;
               if (!r_rx_s) begin
                  w_bit_idx = 3'd0;
                  w_state   = S_DATA;
               end else begin
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_shreg   = {r_rx_s, r_shreg[7:1]};
               w_cnt     = '0;
               w_bit_idx = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state = S_STOP;
               end else begin
                  w_state = S_DATA;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt = '0;
               if (r_rx_s) begin
                  w_d_out = r_shreg;
                  w_valid = 1'b1;
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end else begin
                  // Hold busy until the line returns high so a break is not re-read as a start.
                  w_frame_err = 1'b1;
                  w_state     = S_WAIT_HIGH;
               end
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_WAIT_HIGH: begin
            if (r_rx_s) begin
               w_busy  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_state = S_WAIT_HIGH;
            end
         end
         default: begin
            w_cnt   = '0;
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
      endcase
   end

   assign d_out     = r_d_out;
   assign valid     = r_valid;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 16 clks/bit for the functional cases,
// one at the default 435 clks/bit for the latency check.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx16;
   logic       rx435;
   logic [7:0] d16;
   logic [7:0] d435;
   logic       v16, v435, b16, b435, fe16, fe435;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .reset(reset), .rx(rx16),
      .d_out(d16), .valid(v16), .busy(b16), .frame_err(fe16)
   );

   uart_rx #(.CLKS_PER_BIT(435)) dut435 (
      .clk(clk), .reset(reset), .rx(rx435),
      .d_out(d435), .valid(v435), .busy(b435), .frame_err(fe435)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0_435   = 0;

   // Event monitors sampled on the falling edge, away from the active edge.
   int nv16 = 0, nfe16 = 0, nbusy16 = 0, busy_at_v16 = 0, nboth = 0;
   int nv435 = 0, nfe435 = 0, v435_cyc = 0;
   logic [7:0] q16[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (v16) begin
         nv16 <= nv16 + 1;
         q16.push_back(d16);
         if (b16) busy_at_v16 <= busy_at_v16 + 1;
      end
      if (fe16) nfe16 <= nfe16 + 1;
      if (b16) nbusy16 <= nbusy16 + 1;
      if ((v16 && fe16) || (v435 && fe435)) nboth <= nboth + 1;
      if (v435) begin
         nv435    <= nv435 + 1;
         v435_cyc <= cyc;
      end
      if (fe435) nfe435 <= nfe435 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input bit big, input logic val, input int n);
      if (big) rx435 = val;
      else     rx16  = val;
      repeat (n) tick();
   endtask

   task automatic send_byte(input bit big, input logic [7:0] b, input logic stop_bit);
      int cpb;
      cpb = big ? 435 : 16;
      if (big) t0_435 = cyc;
      drive_bit(big, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(big, b[i], cpb);
      drive_bit(big, stop_bit, cpb);
   endtask

   initial begin
      int s_v, s_fe, s_bv, s_busy, s_q, exp_cyc;
      logic [7:0] b5a;

      reset = 1'b0;
      rx16  = 1'b1;
      rx435 = 1'b1;
      idle(3);
      check("rst_d16", {24'd0, d16}, 32'h00);
      check("rst_v16", {31'd0, v16}, 32'd0);
      check("rst_b16", {31'd0, b16}, 32'd0);
      check("rst_fe16", {31'd0, fe16}, 32'd0);
      check("rst_d435", {24'd0, d435}, 32'h00);
      check("rst_b435", {31'd0, b435}, 32'd0);
      reset = 1'b1;
      idle(5);

      // Basic byte 0xA5
      s_v = nv16; s_fe = nfe16; s_bv = busy_at_v16;
      send_byte(1'b0, 8'hA5, 1'b1);
      idle(20);
      check("basic_nvalid", nv16 - s_v, 32'd1);
      check("basic_dout", {24'd0, d16}, 32'hA5);
      check("basic_nferr", nfe16 - s_fe, 32'd0);
      check("basic_busy_at_valid", busy_at_v16 - s_bv, 32'd0);
      check("basic_busy_idle", {31'd0, b16}, 32'd0);

      // False start: 4-cycle low glitch, rejected at the half-bit sample
      s_v = nv16; s_fe = nfe16; s_busy = nbusy16;
      drive_bit(1'b0, 1'b0, 4);
      drive_bit(1'b0, 1'b1, 20);
      check("false_busy_cycles", nbusy16 - s_busy, 32'd8);
      check("false_nvalid", nv16 - s_v, 32'd0);
      check("false_nferr", nfe16 - s_fe, 32'd0);
      check("false_dout", {24'd0, d16}, 32'hA5);

      // Framing error after a good 0x11
      s_v = nv16;
      send_byte(1'b0, 8'h11, 1'b1);
      idle(10);
      check("fe_pre_nvalid", nv16 - s_v, 32'd1);
      check("fe_pre_dout", {24'd0, d16}, 32'h11);
      s_v = nv16; s_fe = nfe16;
      send_byte(1'b0, 8'h3C, 1'b0);
      drive_bit(1'b0, 1'b0, 40);
      check("fe_nferr", nfe16 - s_fe, 32'd1);
      check("fe_nvalid", nv16 - s_v, 32'd0);
      check("fe_dout_kept", {24'd0, d16}, 32'h11);
      check("fe_busy_held", {31'd0, b16}, 32'd1);
      drive_bit(1'b0, 1'b1, 5);
      check("fe_busy_release", {31'd0, b16}, 32'd0);
      s_busy = nbusy16;
      idle(40);
      check("fe_no_restart", nbusy16 - s_busy, 32'd0);
      check("fe_nferr_final", nfe16 - s_fe, 32'd1);

      // Back-to-back 0x00 then 0xFF, no idle gap
      s_v = nv16; s_q = q16.size();
      send_byte(1'b0, 8'h00, 1'b1);
      send_byte(1'b0, 8'hFF, 1'b1);
      idle(20);
      check("b2b_nvalid", nv16 - s_v, 32'd2);
      check("b2b_first", {24'd0, q16[s_q]}, 32'h00);
      check("b2b_second", {24'd0, q16[s_q + 1]}, 32'hFF);
      check("b2b_dout", {24'd0, d16}, 32'hFF);

      // Reset during data bit 3 of 0x5A
      s_v = nv16;
      b5a = 8'h5A;
      drive_bit(1'b0, 1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(1'b0, b5a[i], 16);
      drive_bit(1'b0, b5a[3], 8);
      check("rstmid_busy_before", {31'd0, b16}, 32'd1);
      reset = 1'b0;
      #1;
      check("rstmid_dout", {24'd0, d16}, 32'h00);
      check("rstmid_valid", {31'd0, v16}, 32'd0);
      check("rstmid_busy", {31'd0, b16}, 32'd0);
      check("rstmid_ferr", {31'd0, fe16}, 32'd0);
      idle(2);
      rx16  = 1'b1;
      reset = 1'b1;
      idle(10);
      check("rstmid_no_valid", nv16 - s_v, 32'd0);
      send_byte(1'b0, 8'hC3, 1'b1);
      idle(20);
      check("rstmid_post_nvalid", nv16 - s_v, 32'd1);
      check("rstmid_post_dout", {24'd0, d16}, 32'hC3);

      // Default timing: 0x81 at 435 clks/bit, latency = start + 3 + 217 + 9*435
      s_v = nv435;
      send_byte(1'b1, 8'h81, 1'b1);
      idle(20);
      check("def_nvalid", nv435 - s_v, 32'd1);
      check("def_dout", {24'd0, d435}, 32'h81);
      check("def_nferr", nfe435, 32'd0);
      exp_cyc = t0_435 + 3 + 217 + 9 * 435;
      n_assert++;
      assert ((v435_cyc >= exp_cyc - 1) && (v435_cyc <= exp_cyc + 1)) else begin
         n_fail++;
         $error("FAIL def_latency: observed cycle %0d expected %0d +/-1", v435_cyc, exp_cyc);
      end

      check("never_both_pulses", nboth, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
